// File: rtl/vga_timing_gen.sv
// VGA pixel-timing source: clock divider to a pixel enable, horizontal/vertical scan
// counters, registered sync/blank strobes and line/frame pulses.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic [9:0] h_counter,
    output logic [9:0] v_counter,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK_N,
    output logic       VGA_SYNC_N,
    output logic       VGA_CLK,
    output logic       pix_ce,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [7:0]       fc_q, fc_d;
    logic             hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
    logic             vclk_q, vclk_d, ls_q, ls_d, fs_q, fs_d;
    logic             pix_ce_w, h_wrap, v_wrap;

    always_comb begin
        pix_ce_w = enable && (div_q == DIV_LAST);
        h_wrap   = (h_q == H_LAST);
        v_wrap   = (v_q == V_LAST);

        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        fc_d  = fc_q;

        if (enable) begin
            div_d = pix_ce_w ? '0 : div_q + DIV_W'(1);
        end

        if (pix_ce_w) begin
            if (h_wrap) begin
                h_d = '0;
                if (v_wrap) begin
                    v_d  = '0;
                    fc_d = fc_q + 8'd1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        // Strobes decode the next coordinates so they change on the same edge as the counters.
        hs_d    = ((h_d >= HS_START) && (h_d < HS_END)) ? HS_POL : ~HS_POL;
        vs_d    = ((v_d >= VS_START) && (v_d < VS_END)) ? VS_POL : ~VS_POL;
        blank_d = (h_d < 10'(H_ACTIVE)) && (v_d < 10'(V_ACTIVE));
        vclk_d  = (div_d >= DIV_HALF);
        ls_d    = pix_ce_w && h_wrap;
        fs_d    = pix_ce_w && h_wrap && v_wrap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            fc_q    <= '0;
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b1;
            vclk_q  <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            fc_q    <= fc_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            vclk_q  <= vclk_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign h_counter   = h_q;
    assign v_counter   = v_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b0;
    assign VGA_CLK     = vclk_q;
    assign pix_ce      = pix_ce_w;
    // Pulses are suppressed while the scan is frozen.
    assign line_start  = ls_q && enable;
    assign frame_start = fs_q && enable;
    assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a tiny, fast-wrapping
// instance are compared every cycle against an arithmetic model of pixel time.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    always #5 clk = ~clk;

    logic [9:0] h_b, v_b, h_s, v_s;
    logic       hs_b, vs_b, bl_b, sy_b, vc_b, pc_b, ls_b, fs_b;
    logic       hs_s, vs_s, bl_s, sy_s, vc_s, pc_s, ls_s, fs_s;
    logic [7:0] fc_b, fc_s;

    vga_timing_gen u_big (
        .clk(clk), .reset(reset), .enable(enable),
        .h_counter(h_b), .v_counter(v_b), .VGA_HS(hs_b), .VGA_VS(vs_b),
        .VGA_BLANK_N(bl_b), .VGA_SYNC_N(sy_b), .VGA_CLK(vc_b), .pix_ce(pc_b),
        .line_start(ls_b), .frame_start(fs_b), .frame_count(fc_b)
    );

    vga_timing_gen #(
        .CLK_DIV(4), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_sml (
        .clk(clk), .reset(reset), .enable(enable),
        .h_counter(h_s), .v_counter(v_s), .VGA_HS(hs_s), .VGA_VS(vs_s),
        .VGA_BLANK_N(bl_s), .VGA_SYNC_N(sy_s), .VGA_CLK(vc_s), .pix_ce(pc_s),
        .line_start(ls_s), .frame_start(fs_s), .frame_count(fc_s)
    );

    int      total = 0;
    int      bad   = 0;
    int      cyc_cnt = 0;
    longint  n_b = 0, n_s = 0;   // enabled clk edges since reset release
    bit      adv_b = 0, adv_s = 0; // previous edge completed a pixel period

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // Pixel time p = n / D; every coordinate and strobe follows from p by division.
    task automatic check_model(input string tag, input int D,
                               input int HA, input int HF, input int HS, input int HB,
                               input int VA, input int VF, input int VS, input int VB,
                               input bit hpol, input bit vpol, input longint n, input bit adv,
                               input logic [9:0] h_o, input logic [9:0] v_o,
                               input logic hs_o, input logic vs_o, input logic bl_o,
                               input logic sy_o, input logic vc_o, input logic pc_o,
                               input logic ls_o, input logic fs_o, input logic [7:0] fc_o);
        longint ht, vt, p, h, v, fc, dv;
        bit e_hs, e_vs, e_bl, e_ls, e_fs, e_pc, e_vc;
        ht = HA + HF + HS + HB;
        vt = VA + VF + VS + VB;
        p  = n / D;
        dv = n % D;
        h  = p % ht;
        v  = (p / ht) % vt;
        fc = (p / (ht * vt)) % 256;
        e_hs = (h >= HA + HF && h < HA + HF + HS) ? hpol : ~hpol;
        e_vs = (v >= VA + VF && v < VA + VF + VS) ? vpol : ~vpol;
        e_bl = (h < HA) && (v < VA);
        e_pc = enable && (dv == D - 1);
        e_vc = (dv >= D / 2);
        e_ls = adv && enable && (h == 0);
        e_fs = e_ls && (v == 0);
        chk({tag, "_h"}, 32'(h_o), 32'(h));
        chk({tag, "_v"}, 32'(v_o), 32'(v));
        chk({tag, "_hs"}, 32'(hs_o), 32'(e_hs));
        chk({tag, "_vs"}, 32'(vs_o), 32'(e_vs));
        chk({tag, "_blank_n"}, 32'(bl_o), 32'(e_bl));
        chk({tag, "_sync_n"}, 32'(sy_o), 32'd0);
        chk({tag, "_vga_clk"}, 32'(vc_o), 32'(e_vc));
        chk({tag, "_pix_ce"}, 32'(pc_o), 32'(e_pc));
        chk({tag, "_line_start"}, 32'(ls_o), 32'(e_ls));
        chk({tag, "_frame_start"}, 32'(fs_o), 32'(e_fs));
        chk({tag, "_frame_count"}, 32'(fc_o), 32'(fc));
    endtask

    task automatic check_all();
        check_model("big", 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, n_b, adv_b,
                    h_b, v_b, hs_b, vs_b, bl_b, sy_b, vc_b, pc_b, ls_b, fs_b, fc_b);
        check_model("sml", 4, 4, 1, 2, 1, 2, 1, 1, 1, 1'b1, 1'b1, n_s, adv_s,
                    h_s, v_s, hs_s, vs_s, bl_s, sy_s, vc_s, pc_s, ls_s, fs_s, fc_s);
    endtask

    // One clk: advance the model at the edge, drive new inputs 1 time unit later, check at negedge.
    task automatic cyc(input bit en_next, input bit rst_n_next);
        @(posedge clk);
        cyc_cnt++;
        if (!reset) begin
            n_b = 0; adv_b = 0; n_s = 0; adv_s = 0;
        end else if (enable) begin
            n_b++; adv_b = (n_b % 2 == 0);
            n_s++; adv_s = (n_s % 4 == 0);
        end else begin
            adv_b = 0; adv_s = 0;
        end
        #1;
        enable = en_next;
        reset  = rst_n_next;
        if (!reset) begin
            n_b = 0; adv_b = 0; n_s = 0; adv_s = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int guard, t0, hs_low, fs_seen;
        logic [9:0] hold_h, hold_v;
        logic       hold_vc, hold_hs;

        reset  = 1'b0;
        enable = 1'b0;
        repeat (5) cyc(1'b0, 1'b0);
        chk("rst_h", 32'(h_b), 32'd0);
        chk("rst_hs", 32'(hs_b), 32'd1);
        chk("rst_vs", 32'(vs_b), 32'd1);
        chk("rst_blank_n", 32'(bl_b), 32'd1);
        chk("rst_vga_clk", 32'(vc_b), 32'd0);

        // Line period and HS width on the full-size timing.
        cyc(1'b1, 1'b1);
        guard = 0;
        while (ls_b !== 1'b1 && guard < 2000) begin cyc(1'b1, 1'b1); guard++; end
        chk("first_line_start_seen", 32'(guard < 2000), 32'd1);
        t0 = cyc_cnt; hs_low = 0; guard = 0;
        do begin
            cyc(1'b1, 1'b1);
            if (hs_b === 1'b0) hs_low++;
            guard++;
        end while (ls_b !== 1'b1 && guard < 2000);
        chk("line_period_clk", 32'(cyc_cnt - t0), 32'd1600);
        chk("hs_low_clk", 32'(hs_low), 32'd192);

        // Freeze mid-line for 37 clks.
        guard = 0;
        while (h_b !== 10'd300 && guard < 2000) begin cyc(1'b1, 1'b1); guard++; end
        chk("reach_h300", 32'(guard < 2000), 32'd1);
        cyc(1'b0, 1'b1);
        hold_h = h_b; hold_v = v_b; hold_vc = vc_b; hold_hs = hs_b;
        repeat (36) begin
            cyc(1'b0, 1'b1);
            chk("frz_h", 32'(h_b), 32'(hold_h));
            chk("frz_v", 32'(v_b), 32'(hold_v));
            chk("frz_vga_clk", 32'(vc_b), 32'(hold_vc));
            chk("frz_hs", 32'(hs_b), 32'(hold_hs));
        end
        guard = 0;
        while (h_b === hold_h && guard < 10) begin cyc(1'b1, 1'b1); guard++; end
        chk("resume_next_pixel", 32'(h_b), 32'(hold_h + 10'd1));

        // Randomised enable gaps.
        repeat (3000) cyc($urandom_range(0, 7) != 0, 1'b1);

        // Asynchronous reset mid-line, then restart without a frame pulse.
        guard = 0;
        while (h_b !== 10'd500 && guard < 2000) begin cyc(1'b1, 1'b1); guard++; end
        chk("reach_h500", 32'(guard < 2000), 32'd1);
        cyc(1'b1, 1'b0);
        chk("arst_h", 32'(h_b), 32'd0);
        chk("arst_frame_start", 32'(fs_b), 32'd0);
        repeat (3) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        fs_seen = 0; guard = 0;
        while (h_b !== 10'd1 && guard < 10) begin
            cyc(1'b1, 1'b1);
            if (fs_b === 1'b1 || ls_b === 1'b1) fs_seen++;
            guard++;
        end
        chk("restart_h1", 32'(h_b), 32'd1);
        chk("restart_no_pulse", 32'(fs_seen), 32'd0);

        // frame_count wrap on the small instance.
        guard = 0;
        while (fc_s !== 8'd255 && guard < 42000) begin cyc(1'b1, 1'b1); guard++; end
        chk("reach_fc255", 32'(guard < 42000), 32'd1);
        guard = 0;
        while (fc_s === 8'd255 && guard < 400) begin cyc(1'b1, 1'b1); guard++; end
        chk("wrap_fc", 32'(fc_s), 32'd0);
        chk("wrap_frame_start", 32'(fs_s), 32'd1);
        chk("wrap_line_start", 32'(ls_s), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
